// File: rtl/dmem_responder.sv
// Word-RAM responder for the core load/store port: one access at a time, ready pulses LATENCY cycles after accept.
// No backpressure: req is only looked at in IDLE (accept) and WAIT (drop = abort); outputs are registered.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    mem [DEPTH];

    logic           eff_we;
    logic [31:0]    eff_addr;
    logic           eff_bad;
    logic [AW-1:0]  eff_idx;

    // Live inputs are the request only in the accept cycle; afterwards the latched copy rules.
    always_comb begin
        eff_we   = (state == IDLE) ? we : we_q;
        eff_addr = (state == IDLE) ? addr : addr_q;
        eff_bad  = (eff_addr[1:0] != 2'b00) || (eff_addr[31:2] >= 30'(DEPTH));
        eff_idx  = eff_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter holds the WAIT cycles still to run; leaving on the last one lands RESP at T+LATENCY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = CW'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 1'b1;
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt <= CW'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= (state_nxt == RESP);
            err   <= (state_nxt == RESP) && eff_bad;
            rdata <= ((state_nxt == RESP) && !eff_we && !eff_bad) ? mem[eff_idx] : '0;
        end
    end

    // Store commits on the edge closing RESP; a reset on that edge drops it.
    always_ff @(posedge clk) begin
        if (state == RESP && !reset && we_q && !eff_bad) begin
            mem[eff_idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 instance for table and corner sequences, LATENCY=1 instance for back-to-back.
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req0, we0, ready0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        req1, we1, ready1, err1;
    logic [31:0] addr1, wdata1, rdata1;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .ready(ready0), .err(err0)
    );
    dmem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .ready(ready1), .err(err1)
    );

    typedef struct { logic [31:0] rd; logic err; int due; } exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic err; logic [31:0] rd; } vec_t;

    exp_t        q0[$];
    exp_t        q1[$];
    vec_t        vecs[12];
    logic [31:0] model [64];
    int checks = 0, errors = 0, cyc = 0, resp0 = 0, resp1 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) begin : mon0
        exp_t e;
        #1;
        if (ready0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready0: ready=1 with no access pending (cycle %0d)", cyc);
            end else begin
                e = q0.pop_front();
                chk("rdata0", rdata0, e.rd);
                chk("err0", err0, e.err);
                chk("ready0_cycle", cyc, e.due);
            end
            resp0++;
        end
    end

    always @(posedge clk) begin : mon1
        exp_t e;
        #1;
        if (ready1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready1: ready=1 with no access pending (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("rdata1", rdata1, e.rd);
                chk("err1", err1, e.err);
                chk("ready1_cycle", cyc, e.due);
            end
            resp1++;
        end
    end

    task automatic start0(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        e.rd = e_rd; e.err = e_err; e.due = cyc + 2;
        q0.push_back(e);
        @(posedge clk); #1;
        // scramble the fields after accept; the latched copy must be used
        we0 = ~w; addr0 = ~a; wdata0 = ~d;
    endtask

    task automatic wait0(input int n0, input bit settle);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk); #2;
            if (resp0 != n0) got = 1'b1;
        end
        req0 = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout0: no ready within 12 cycles, expected one");
            q0.delete();
        end
        if (settle) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd);
        int n0;
        n0 = resp0;
        start0(w, a, d, e_err, e_rd);
        wait0(n0, 1'b1);
        if (w && !e_err) model[a[7:2]] = d;
    endtask

    task automatic st1(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
        e.rd = 32'h0; e.err = 1'b0; e.due = cyc + 1;
        q1.push_back(e);
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n0;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready0", ready0, 0); chk("reset_err0", err0, 0); chk("reset_rdata0", rdata0, 0);
        chk("reset_ready1", ready1, 0); chk("reset_err1", err1, 0); chk("reset_rdata1", rdata1, 0);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 64; i++) acc0(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0, 32'h0);

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h1000_0001};
        vecs[4]  = '{1'b1, 32'h0000_0100, 32'hAAAA_5555, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_000A, 32'h0BAD_F00D, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'h1000_0003};
        vecs[9]  = '{1'b1, 32'h0000_00FC, 32'h5A5A_5A5A, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h5A5A_5A5A};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
        for (int i = 0; i < 12; i++) acc0(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rd);

        // abort: req dropped in WAIT, no pulse, no write
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h1234_5678;
        @(posedge clk); #1;
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort_no_ready", ready0, 0);
        end
        acc0(1'b0, 32'h10, 32'h0, 1'b0, model[4]);

        // reset during RESP of a store: dropped write, earlier data survives
        n0 = resp0;
        start0(1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, 32'h0);
        wait0(n0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_resp_ready", ready0, 0); chk("rst_resp_err", err0, 0); chk("rst_resp_rdata", rdata0, 0);
        reset = 1'b0;
        @(posedge clk); #2;
        acc0(1'b0, 32'h20, 32'h0, 1'b0, model[8]);
        acc0(1'b0, 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF);

        for (int i = 0; i < 64; i++) acc0(1'b0, 32'(i * 4), 32'h0, 1'b0, model[i]);

        // LATENCY=1: back-to-back loads with req held; req also held through the second RESP
        st1(32'h0, 32'hA0A0_0001);
        st1(32'h4, 32'hB0B0_0002);
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0;
        e.rd = 32'hA0A0_0001; e.err = 1'b0; e.due = cyc + 1;
        q1.push_back(e);
        @(posedge clk); #1;
        addr1 = 32'h4;
        e.rd = 32'hB0B0_0002; e.err = 1'b0; e.due = cyc + 2;
        q1.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("resp1_count", resp1, 4);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
